// File: rtl/branch_queue_ctrl.sv
// In-order circular branch queue: decode allocates at the tail, the branch unit
// resolves out of order (mispredicts truncate younger entries), commit pops the head.
module branch_queue_ctrl #(
    parameter int   NR_ENTRIES = 8,
    parameter int   PC_W       = 64,
    parameter int   ID_W       = 6,
    localparam int  BQID_W     = $clog2(NR_ENTRIES)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [PC_W-1:0]   push_pc,
    input  logic [ID_W-1:0]   push_id,
    input  logic              push_bp_taken,
    input  logic [PC_W-1:0]   push_bp_pcnext,
    output logic [BQID_W-1:0] push_bqid,
    input  logic              res_valid,
    input  logic [BQID_W-1:0] res_bqid,
    input  logic              res_taken,
    input  logic [PC_W-1:0]   res_target,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [ID_W-1:0]   redirect_id,
    input  logic              commit_valid,
    output logic [BQID_W-1:0] head_bqid,
    output logic              head_resolved,
    input  logic              flush_i,
    output logic              full_o,
    output logic              empty_o
);

    localparam int CNT_W = BQID_W + 1;

    logic [NR_ENTRIES-1:0] valid_q, valid_d;
    logic [NR_ENTRIES-1:0] resolved_q, resolved_d;
    logic [PC_W-1:0]       pc_q        [NR_ENTRIES];
    logic [ID_W-1:0]       id_q        [NR_ENTRIES];
    logic                  bp_taken_q  [NR_ENTRIES];
    logic [PC_W-1:0]       bp_pcnext_q [NR_ENTRIES];

    logic [BQID_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic [ID_W-1:0]   redirect_id_q, redirect_id_d;

    logic              res_hit, res_ok, mispredict, mis_fire;
    logic              push_en, pop_en;
    logic [BQID_W-1:0] age_res;
    logic [PC_W-1:0]   correct_pc;

    assign full_o        = (count_q == CNT_W'(NR_ENTRIES));
    assign empty_o       = (count_q == '0);
    assign push_ready    = !full_o && !redirect_valid_q && !flush_i;
    assign push_bqid     = tail_q;
    assign head_bqid     = head_q;
    assign head_resolved = valid_q[head_q] && resolved_q[head_q];

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign redirect_id    = redirect_id_q;

    // Resolves are ignored while a redirect is being delivered and during flush.
    assign res_hit    = res_valid && !redirect_valid_q && !flush_i && valid_q[res_bqid];
    assign res_ok     = res_hit && !resolved_q[res_bqid];
    assign mispredict = (res_taken != bp_taken_q[res_bqid]) ||
                        (res_taken && (res_target != bp_pcnext_q[res_bqid]));
    assign mis_fire   = res_ok && mispredict;
    assign correct_pc = res_taken ? res_target : (pc_q[res_bqid] + PC_W'(4));
    assign age_res    = res_bqid - head_q;

    assign push_en = push_valid && push_ready && !mis_fire;
    assign pop_en  = commit_valid && head_resolved && !flush_i;

    generate
        for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_slot
            localparam logic [BQID_W-1:0] SLOT = BQID_W'(gi);
            logic [BQID_W-1:0] age;
            logic              younger, is_push, is_pop, is_res;

            assign age     = SLOT - head_q;
            assign younger = mis_fire && (age > age_res);
            assign is_push = push_en && (tail_q == SLOT);
            assign is_pop  = pop_en && (head_q == SLOT);
            assign is_res  = res_ok && (res_bqid == SLOT);

            assign valid_d[gi] = flush_i ? 1'b0 :
                                 (younger || is_pop) ? 1'b0 :
                                 is_push ? 1'b1 : valid_q[gi];
            assign resolved_d[gi] = flush_i ? 1'b0 :
                                    (younger || is_pop || is_push) ? 1'b0 :
                                    is_res ? 1'b1 : resolved_q[gi];
        end
    endgenerate

    always_comb begin
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        redirect_id_d    = redirect_id_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop_en) begin
                head_d = head_q + BQID_W'(1);
            end
            if (mis_fire) begin
                // Everything younger than the mispredicted branch is discarded.
                tail_d           = res_bqid + BQID_W'(1);
                count_d          = CNT_W'(age_res) + CNT_W'(1) - CNT_W'(pop_en);
                redirect_valid_d = 1'b1;
                redirect_pc_d    = correct_pc;
                redirect_id_d    = id_q[res_bqid];
            end else begin
                if (push_en) begin
                    tail_d = tail_q + BQID_W'(1);
                end
                count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q          <= '0;
            resolved_q       <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            redirect_id_q    <= '0;
        end else begin
            valid_q          <= valid_d;
            resolved_q       <= resolved_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_id_q    <= redirect_id_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            pc_q[tail_q]        <= push_pc;
            id_q[tail_q]        <= push_id;
            bp_taken_q[tail_q]  <= push_bp_taken;
            bp_pcnext_q[tail_q] <= push_bp_pcnext;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (count_q <= CNT_W'(NR_ENTRIES));
            assert (!(push_en && valid_q[tail_q]));
            assert (!(commit_valid && !flush_i && !head_resolved));
            assert (!(res_hit && resolved_q[res_bqid]));
        end
    end

endmodule

// File: tb/tb_branch_queue_ctrl.sv
// Bench for branch_queue_ctrl: directed scenarios followed by random traffic,
// all checked against an ordered-queue model of the branch queue.
module tb_branch_queue_ctrl;
    localparam int N    = 8;
    localparam int PC_W = 64;
    localparam int ID_W = 6;
    localparam int BW   = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic            push_valid, push_ready, push_bp_taken;
    logic [PC_W-1:0] push_pc, push_bp_pcnext;
    logic [ID_W-1:0] push_id;
    logic [BW-1:0]   push_bqid;
    logic            res_valid, res_taken;
    logic [BW-1:0]   res_bqid;
    logic [PC_W-1:0] res_target;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic [ID_W-1:0] redirect_id;
    logic            commit_valid;
    logic [BW-1:0]   head_bqid;
    logic            head_resolved, flush_i, full_o, empty_o;

    always #5 clk = ~clk;

    branch_queue_ctrl #(.NR_ENTRIES(N), .PC_W(PC_W), .ID_W(ID_W)) dut (
        .clk(clk), .rstn(rstn),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_id(push_id), .push_bp_taken(push_bp_taken), .push_bp_pcnext(push_bp_pcnext),
        .push_bqid(push_bqid),
        .res_valid(res_valid), .res_bqid(res_bqid), .res_taken(res_taken), .res_target(res_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_id(redirect_id),
        .commit_valid(commit_valid), .head_bqid(head_bqid), .head_resolved(head_resolved),
        .flush_i(flush_i), .full_o(full_o), .empty_o(empty_o)
    );

    typedef struct {
        logic [BW-1:0]   bqid;
        logic [PC_W-1:0] pc;
        logic [ID_W-1:0] id;
        logic            bpt;
        logic [PC_W-1:0] bpn;
        logic            res;
    } ent_t;

    ent_t            q[$];
    int              m_head;
    logic            m_rv;
    logic [PC_W-1:0] m_rpc;
    logic [ID_W-1:0] m_rid;
    bit              m_init = 0;
    int              total  = 0;
    int              passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int m_tail();
        return (m_head + q.size()) % N;
    endfunction

    function automatic bit m_hr();
        return (q.size() > 0) && q[0].res;
    endfunction

    task automatic idle();
        push_valid = 0; push_pc = '0; push_id = '0; push_bp_taken = 0; push_bp_pcnext = '0;
        res_valid = 0; res_bqid = '0; res_taken = 0; res_target = '0;
        commit_valid = 0; flush_i = 0;
    endtask

    task automatic check_outputs();
        chk("push_ready", 64'(push_ready), 64'((q.size() != N) && !m_rv && !flush_i));
        chk("push_bqid", 64'(push_bqid), 64'(m_tail()));
        chk("full", 64'(full_o), 64'(q.size() == N));
        chk("empty", 64'(empty_o), 64'(q.size() == 0));
        chk("head_bqid", 64'(head_bqid), 64'(m_head));
        chk("head_resolved", 64'(head_resolved), 64'(m_hr()));
        chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
        if (m_rv) begin
            chk("redirect_pc", redirect_pc, m_rpc);
            chk("redirect_id", 64'(redirect_id), 64'(m_rid));
        end
    endtask

    task automatic model_update();
        bit   mis, pr, hr;
        ent_t e;
        if (!rstn) begin
            q.delete(); m_head = 0; m_rv = 0; m_rpc = '0; m_rid = '0; m_init = 1;
            return;
        end
        if (!m_init) return;
        if (flush_i) begin
            q.delete(); m_head = 0; m_rv = 0;
            return;
        end
        mis = 0;
        pr  = (q.size() != N) && !m_rv;
        hr  = m_hr();
        if (res_valid && !m_rv) begin
            for (int k = 0; k < q.size(); k++) begin
                if (q[k].bqid == res_bqid && !q[k].res) begin
                    q[k].res = 1;
                    mis = (res_taken != q[k].bpt) || (res_taken && res_target != q[k].bpn);
                    if (mis) begin
                        m_rpc = res_taken ? res_target : q[k].pc + 64'd4;
                        m_rid = q[k].id;
                        while (q.size() > k + 1) void'(q.pop_back());
                    end
                    break;
                end
            end
        end
        if (push_valid && pr && !mis) begin
            e.bqid = BW'(m_tail()); e.pc = push_pc; e.id = push_id;
            e.bpt = push_bp_taken; e.bpn = push_bp_pcnext; e.res = 0;
            q.push_back(e);
        end
        if (commit_valid && hr) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % N;
        end
        m_rv = mis;
    endtask

    task automatic step();
        #1;
        if (m_init) check_outputs();
        model_update();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic do_push(input logic [PC_W-1:0] pc, input int id, input logic bpt,
                           input logic [PC_W-1:0] bpn);
        push_valid = 1; push_pc = pc; push_id = ID_W'(id);
        push_bp_taken = bpt; push_bp_pcnext = bpn;
        step();
    endtask

    task automatic do_res(input int b, input logic tk, input logic [PC_W-1:0] tgt);
        res_valid = 1; res_bqid = BW'(b); res_taken = tk; res_target = tgt;
        step();
    endtask

    initial begin
        rstn = 0;
        idle();
        step();
        step();
        rstn = 1;
        chk("rst_push_ready", 64'(push_ready), 64'(1));
        chk("rst_empty", 64'(empty_o), 64'(1));
        chk("rst_full", 64'(full_o), 64'(0));
        chk("rst_head_resolved", 64'(head_resolved), 64'(0));
        chk("rst_redirect_valid", 64'(redirect_valid), 64'(0));
        chk("rst_redirect_pc", redirect_pc, 64'(0));
        chk("rst_redirect_id", 64'(redirect_id), 64'(0));
        chk("rst_bqid", 64'(push_bqid), 64'(0));

        // Fill the queue, then try one more
        for (int i = 0; i < 8; i++) begin
            chk("fill_bqid", 64'(push_bqid), 64'(i));
            do_push(64'h100 + 64'(4 * i), i, 1'b0, 64'h0);
        end
        chk("fill_full", 64'(full_o), 64'(1));
        chk("fill_ready", 64'(push_ready), 64'(0));
        do_push(64'h120, 8, 1'b0, 64'h0);
        chk("refused_tail", 64'(push_bqid), 64'(0));
        chk("refused_full", 64'(full_o), 64'(1));

        // Mispredict on bqid 3 with six entries
        flush_i = 1; step();
        for (int i = 0; i < 6; i++) do_push(64'h100 + 64'(4 * i), 10 + i, 1'b0, 64'h0);
        do_res(3, 1'b1, 64'h400);
        chk("mis_rv", 64'(redirect_valid), 64'(1));
        chk("mis_rpc", redirect_pc, 64'h400);
        chk("mis_rid", 64'(redirect_id), 64'(13));
        chk("mis_tail", 64'(push_bqid), 64'(4));
        chk("mis_ready", 64'(push_ready), 64'(0));
        step();
        chk("mis_pulse", 64'(redirect_valid), 64'(0));
        do_res(4, 1'b1, 64'h999);
        chk("trunc_slot_ignored", 64'(redirect_valid), 64'(0));

        // Not-taken mispredict and a correct taken prediction
        do_push(64'h200, 20, 1'b1, 64'h300);
        do_push(64'h280, 21, 1'b1, 64'h300);
        do_res(5, 1'b1, 64'h300);
        chk("correct_pred", 64'(redirect_valid), 64'(0));
        do_res(4, 1'b0, 64'h0);
        chk("nt_rv", 64'(redirect_valid), 64'(1));
        chk("nt_rpc", redirect_pc, 64'h204);
        chk("nt_rid", 64'(redirect_id), 64'(20));
        chk("nt_tail", 64'(push_bqid), 64'(5));

        // Wrap-around with push/resolve/commit
        flush_i = 1; step();
        for (int i = 0; i < 10; i++) begin
            chk("wrap_bqid", 64'(push_bqid), 64'(i % 8));
            do_push(64'h1000 + 64'(4 * i), i, 1'b0, 64'h0);
            do_res(i % 8, 1'b0, 64'h0);
            commit_valid = 1; step();
            chk("wrap_head", 64'(head_bqid), 64'((i + 1) % 8));
        end
        chk("wrap_empty", 64'(empty_o), 64'(1));

        // Full queue: pop accepted, simultaneous push refused
        for (int i = 0; i < 8; i++) do_push(64'h3000 + 64'(4 * i), 30 + i, 1'b0, 64'h0);
        do_res(2, 1'b0, 64'h0);
        chk("full_head_res", 64'(head_resolved), 64'(1));
        commit_valid = 1; push_valid = 1; push_pc = 64'h500; push_id = 6'd40;
        #1;
        chk("full_pop_ready", 64'(push_ready), 64'(0));
        step();
        chk("full_pop_notfull", 64'(full_o), 64'(0));
        chk("full_pop_head", 64'(head_bqid), 64'(3));
        chk("full_pop_bqid", 64'(push_bqid), 64'(2));
        do_push(64'h500, 40, 1'b0, 64'h0);
        chk("full_refill", 64'(full_o), 64'(1));

        // Flush beats simultaneous push and mispredicting resolve
        flush_i = 1; step();
        for (int i = 0; i < 5; i++) do_push(64'h600 + 64'(4 * i), 50 + i, 1'b0, 64'h0);
        flush_i = 1; push_valid = 1; push_pc = 64'h700; push_id = 6'd60;
        res_valid = 1; res_bqid = 3'd1; res_taken = 1; res_target = 64'h777;
        step();
        chk("flush_empty", 64'(empty_o), 64'(1));
        chk("flush_head", 64'(head_bqid), 64'(0));
        chk("flush_tail", 64'(push_bqid), 64'(0));
        chk("flush_rv", 64'(redirect_valid), 64'(0));
        chk("flush_ready", 64'(push_ready), 64'(1));

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            int   rb;
            bit   rr;
            rstn       = ($urandom_range(0, 199) != 0);
            flush_i    = ($urandom_range(0, 39) == 0);
            push_valid = 1'($urandom_range(0, 1));
            push_pc    = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                     : {32'h0, $urandom} & ~64'h3;
            push_id        = ID_W'($urandom);
            push_bp_taken  = 1'($urandom_range(0, 1));
            push_bp_pcnext = $urandom_range(0, 1) ? 64'h1000 : 64'h2000;
            rb = $urandom_range(0, N - 1);
            rr = 0;
            foreach (q[k]) if (q[k].bqid == BW'(rb) && q[k].res) rr = 1;
            res_valid    = !rr && ($urandom_range(0, 2) != 0);
            res_bqid     = BW'(rb);
            res_taken    = 1'($urandom_range(0, 1));
            res_target   = $urandom_range(0, 1) ? 64'h1000 : 64'h2000;
            commit_valid = m_hr() && ($urandom_range(0, 1) != 0);
            step();
        end
        rstn = 1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/branch_queue_ctrl.md
Name: branch_queue_ctrl

Overview:
- In-order circular branch queue (BQ) between decode, the branch unit and commit.
- Decode pushes one control-flow instruction per cycle and receives its bqid in the same cycle.
- The branch unit resolves entries out of order. The controller detects mispredictions, emits one registered redirect and truncates younger entries.
- Commit retires entries in order from the head. A global flush empties the queue.

Parameters:
NR_ENTRIES, 8, queue depth (power of two, >=2); BQID_W = $clog2(NR_ENTRIES)
PC_W, 64, program counter width
ID_W, 6, ROB instruction id width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
push_valid  in  1  decode pushes a branch
push_ready  out  1  queue can accept a push this cycle
push_pc  in  PC_W  branch pc
push_id  in  ID_W  ROB id
push_bp_taken  in  1  predicted taken
push_bp_pcnext  in  PC_W  predicted target
push_bqid  out  BQID_W  slot allocated to the current push (= tail)
res_valid  in  1  branch unit resolves an entry
res_bqid  in  BQID_W  entry being resolved
res_taken  in  1  actual direction
res_target  in  PC_W  actual target
redirect_valid  out  1  misprediction redirect, one-cycle pulse
redirect_pc  out  PC_W  correct fetch pc
redirect_id  out  ID_W  ROB id of the mispredicted branch
commit_valid  in  1  ROB retires the head branch
head_bqid  out  BQID_W  current head slot
head_resolved  out  1  head valid and resolved
flush_i  in  1  global flush (exception/redirect from commit)
full_o  out  1  count == NR_ENTRIES
empty_o  out  1  count == 0

Behaviour:
- State:
  - Per slot: valid, resolved, pc, id, bp_taken, bp_pcnext.
  - head and tail pointers of BQID_W bits, wrapping modulo NR_ENTRIES.
  - count of BQID_W+1 bits.
- Reset (rstn=0 at posedge):
  - head=tail=count=0; all valid/resolved=0.
  - redirect_valid=0, redirect_pc=0, redirect_id=0.
  - Outputs: push_ready=1, empty_o=1, full_o=0, head_resolved=0.
  - Reset mid-operation discards all entries and any pending redirect.
- Push:
  - push_ready = !full_o && !redirect_valid && !flush_i (combinational).
  - Accept when push_valid && push_ready.
  - Accepting writes slot[tail], sets valid=1 and resolved=0, then tail++.
  - push_bqid = tail combinationally, valid even when not accepted.
- Resolve:
  - res_valid on a valid, unresolved slot sets resolved=1.
  - res_valid on an invalid slot is ignored.
  - mispredict = (res_taken != bp_taken) || (res_taken && res_target != bp_pcnext).
  - Correct pc = res_taken ? res_target : pc+4, computed modulo 2^PC_W.
  - On mispredict, the next cycle: redirect_valid=1, redirect_pc = correct pc, redirect_id = slot id.
  - On mispredict, at the same edge, every slot younger than res_bqid is invalidated.
    - tail = res_bqid+1.
    - count = (res_bqid - head mod NR_ENTRIES) + 1, adjusted by −1 if a commit pops in the same cycle.
  - A push in the same cycle as a mispredicting resolve is dropped; it is younger by construction.
  - redirect_valid lasts exactly one cycle.
  - During that cycle push_ready=0 and res_valid is ignored.
- Commit:
  - head_resolved = slot[head].valid && slot[head].resolved.
  - commit_valid pops only when head_resolved=1: clears valid, head++, count--.
  - commit_valid with head_resolved=0 is a protocol error: assertion, no state change.
  - Simultaneous push and pop: count is unchanged.
  - Push is refused when full even if a pop occurs in that cycle.
- Flush:
  - flush_i has priority over all other inputs.
  - Next state: head=tail=count=0, all slots invalid, redirect_valid=0.
  - Pushes, resolves and commits in the flush cycle are discarded.
- Wrap-around:
  - Pointers wrap from NR_ENTRIES-1 to 0.
  - Age comparison uses (slot - head) mod NR_ENTRIES.
- Latency: push→bqid 0 cycles; resolve→redirect 1 cycle; commit→head update 1 cycle.
- Assertions:
  - count <= NR_ENTRIES.
  - No push when !push_ready.
  - No resolve of an already-resolved slot.

Test Plan:
- Reset, then push 8 branches (pc 0x100..0x11C, all predicted not-taken) -> bqid 0..7, full_o=1 after 8th, push_ready=0; 9th push refused, tail stays 0.
- Resolve bqid 3 taken, target 0x400, pred not-taken, with 6 entries -> next cycle redirect_valid=1, redirect_pc=0x400, redirect_id=id3; tail=4, count=4, slots 4-5 invalid.
- Resolve not-taken branch at pc 0x200 predicted taken to 0x300 -> redirect_pc=0x204; correct prediction (taken, 0x300 == pcnext) -> no redirect.
- Wrap: push/commit 10 branches with NR_ENTRIES=8 -> bqids 0..7,0,1; head_bqid wraps to 0; empty_o=1 at end.
- Full queue: resolve head and commit while push_valid=1 -> pop accepted, push refused that cycle and accepted the next with push_bqid = old head.
- flush_i with 5 entries, simultaneous push and resolve -> next cycle empty_o=1, head=tail=0, no redirect, push_ready=1.
